// File: rtl/fifo_v4_sram.sv
// rtl/fifo_v4_sram.sv - show-ahead SRAM FIFO with head register, usage count, thresholds and error pulses
module fifo_v4_sram #(
    parameter logic        FALL_THROUGH    = 1'b0,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY_TH = 1,
    parameter int unsigned ADDR_DEPTH      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_DEPTH:0]   usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_DEPTH:0]   DEPTH_U = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH:0]   AF_TH   = (ADDR_DEPTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_DEPTH:0]   AE_TH   = (ADDR_DEPTH+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_DEPTH-1:0] LAST    = ADDR_DEPTH'(DEPTH - 2);
    localparam logic [ADDR_DEPTH:0]   ONE     = (ADDR_DEPTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];
    logic [DATA_WIDTH-1:0] head_q, rdata_q;
    logic [ADDR_DEPTH-1:0] wptr_q, rptr_q;
    logic [ADDR_DEPTH:0]   usage_q, usage_d;
    logic                  head_sel_q;
    logic                  overflow_q, underflow_q;

    logic empty_reg, sram_has, push_ok, pop_ok, wr_en, rd_en, head_load;
    logic unused_testmode;

    assign unused_testmode = testmode_i;

    assign empty_reg = (usage_q == '0);
    assign sram_has  = (usage_q > ONE);
    assign full_o    = (usage_q == DEPTH_U);
    // Fall-through exposes an incoming push on an empty FIFO as the head this cycle.
    assign empty_o   = empty_reg && !(FALL_THROUGH && push_i);
    assign data_o    = (empty_reg && FALL_THROUGH && push_i) ? data_i :
                       head_sel_q ? rdata_q : head_q;

    assign push_ok   = push_i && !full_o && !flush_i;
    assign pop_ok    = pop_i && !empty_o && !flush_i;
    assign rd_en     = pop_ok && sram_has;
    // Push lands in the head register when there is no older element to sit behind.
    assign head_load = push_ok && (empty_reg ? !pop_ok : (pop_ok && !sram_has));
    assign wr_en     = push_ok && !empty_reg && !(pop_ok && !sram_has);

    always_comb begin
        usage_d = usage_q;
        if (push_ok && !pop_ok)
            usage_d = usage_q + ONE;
        else if (pop_ok && !push_ok)
            usage_d = usage_q - ONE;
    end

    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wptr_q] <= data_i;
        if (rd_en)
            rdata_q <= mem[rptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            usage_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            head_q      <= '0;
            head_sel_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= push_i && full_o && !flush_i;
            underflow_q <= pop_i && empty_o && !flush_i;
            if (flush_i) begin
                usage_q    <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                head_sel_q <= 1'b0;
            end else begin
                usage_q <= usage_d;
                if (wr_en)
                    wptr_q <= next_ptr(wptr_q);
                if (rd_en) begin
                    rptr_q     <= next_ptr(rptr_q);
                    head_sel_q <= 1'b1;
                end else if (head_load) begin
                    head_q     <= data_i;
                    head_sel_q <= 1'b0;
                end
            end
        end
    end

    assign usage_o        = usage_q;
    assign almost_full_o  = (usage_q >= AF_TH);
    assign almost_empty_o = (usage_q <= AE_TH);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_v4_sram.sv
// tb/tb_fifo_v4_sram.sv - directed bench for fifo_v4_sram (registered and fall-through instances)
module tb_fifo_v4_sram;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: DEPTH=8, DATA_WIDTH=40, AF=6, AE=2, registered mode
    logic        a_flush = 0, a_push = 0, a_pop = 0;
    logic [39:0] a_din = '0, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0]  a_usage;

    // Instance B: DEPTH=5, DATA_WIDTH=8, fall-through
    logic        b_flush = 0, b_push = 0, b_pop = 0;
    logic [7:0]  b_din = '0, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [3:0]  b_usage;

    fifo_v4_sram #(.FALL_THROUGH(1'b0), .DATA_WIDTH(40), .DEPTH(8),
                   .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(1'b0),
        .data_i(a_din), .push_i(a_push), .data_o(a_dout), .pop_i(a_pop),
        .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af),
        .almost_empty_o(a_ae), .usage_o(a_usage), .overflow_o(a_ovf),
        .underflow_o(a_unf)
    );

    fifo_v4_sram #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(5)) u_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .testmode_i(1'b0),
        .data_i(b_din), .push_i(b_push), .data_o(b_dout), .pop_i(b_pop),
        .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af),
        .almost_empty_o(b_ae), .usage_o(b_usage), .overflow_o(b_ovf),
        .underflow_o(b_unf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check("rst_usage", a_usage, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_ae", a_ae, 1);
        check("rst_af", a_af, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_unf", a_unf, 0);
        check("rst_data", a_dout, 0);
        #8 rst_n = 1'b1;
        step();

        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            a_din = 40'(i); a_push = 1;
            step();
            check("fill_usage", a_usage, 64'(i));
            check("fill_ae", a_ae, (i <= 2) ? 1 : 0);
            check("fill_af", a_af, (i >= 6) ? 1 : 0);
            check("fill_head", a_dout, 1);
        end
        a_push = 0;
        check("fill_full", a_full, 1);

        // Push while full
        a_din = 40'hAA; a_push = 1;
        step();
        a_push = 0;
        check("ovf_pulse", a_ovf, 1);
        check("ovf_usage", a_usage, 8);
        check("ovf_head", a_dout, 1);
        step();
        check("ovf_clear", a_ovf, 0);

        // Drain back-to-back
        a_pop = 1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check("drain_data", a_dout, 64'(i));
            check("drain_empty", a_empty, 0);
            check("drain_af", a_af, (9 - i >= 6) ? 1 : 0);
            step();
        end
        a_pop = 0;
        check("drain_done_empty", a_empty, 1);
        check("drain_done_usage", a_usage, 0);

        // Pop while empty
        a_pop = 1;
        step();
        a_pop = 0;
        check("unf_pulse", a_unf, 1);
        check("unf_usage", a_usage, 0);
        step();
        check("unf_clear", a_unf, 0);

        // Registered mode: push+pop on empty stores the push, rejects the pop
        a_din = 40'h33; a_push = 1; a_pop = 1;
        step();
        a_push = 0; a_pop = 0;
        check("pp_empty_usage", a_usage, 1);
        check("pp_empty_unf", a_unf, 1);
        check("pp_empty_data", a_dout, 40'h33);
        a_pop = 1;
        step();
        a_pop = 0;
        check("pp_drain", a_usage, 0);

        // Flush at usage 4 with a concurrent push
        for (int i = 0; i < 4; i++) begin
            a_din = 40'(16 + i); a_push = 1;
            step();
        end
        check("pre_flush_usage", a_usage, 4);
        a_flush = 1; a_din = 40'h99;
        step();
        a_flush = 0; a_push = 0;
        check("flush_usage", a_usage, 0);
        check("flush_empty", a_empty, 1);
        check("flush_ovf", a_ovf, 0);
        a_din = 40'h77; a_push = 1;
        step();
        a_din = 40'h78;
        step();
        a_push = 0; a_pop = 1;
        #1;
        check("post_flush_head", a_dout, 40'h77);
        step();
        check("post_flush_next", a_dout, 40'h78);
        step();
        a_pop = 0;
        check("post_flush_empty", a_empty, 1);

        // Fall-through pass-through on empty FIFO
        b_din = 8'h55; b_push = 1; b_pop = 1;
        #1;
        check("ft_data", b_dout, 8'h55);
        check("ft_empty", b_empty, 0);
        step();
        b_push = 0; b_pop = 0;
        check("ft_usage", b_usage, 0);
        check("ft_ovf", b_ovf, 0);
        check("ft_unf", b_unf, 0);

        // Fill to 3, then stream 20 cycles across pointer wrap
        for (int i = 1; i <= 3; i++) begin
            b_din = 8'(i); b_push = 1;
            #1;
            check("ft_fill_head", b_dout, 1);
            step();
        end
        for (int k = 4; k <= 23; k++) begin
            b_din = 8'(k); b_push = 1; b_pop = 1;
            #1;
            check("stream_data", b_dout, 64'(k - 3));
            check("stream_usage", b_usage, 3);
            step();
        end
        b_push = 0; b_pop = 0;
        #1;
        check("stream_end_usage", b_usage, 3);
        check("stream_end_head", b_dout, 21);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            a_din = 40'(40 + i); a_push = 1;
            step();
        end
        a_push = 0;
        check("pre_rst_usage", a_usage, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_usage", a_usage, 0);
        check("mid_rst_empty", a_empty, 1);
        check("mid_rst_data", a_dout, 0);
        check("mid_rst_ft_usage", b_usage, 0);
        step();
        rst_n = 1'b1;
        step();
        check("after_rst_empty", a_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
